// File: rtl/usc_ctrl_pkg.sv
// Shared definitions for the error-retry handshake controller: state encoding,
// parameter defaults/limits and a saturating counter helper.
package usc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_CHECK = 3'd2,
        ST_HS    = 3'd3,
        ST_FAIL  = 3'd4
    } ctrl_state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int MAX_WIDTH      = 64;
    localparam int DEF_SAMPLE_DLY = 2;
    localparam int MAX_SAMPLE_DLY = 15;
    localparam int DEF_MAX_RETRY  = 3;
    localparam int MAX_MAX_RETRY  = 7;
    localparam int DEF_RETRY_EN   = 1;

    localparam int TIMER_W = 4;
    localparam int RETRY_W = 3;
    localparam int ERRCNT_W = 8;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/err_retry_ctrl_if.sv
// Bundle of the left/right 4-phase handshakes plus the error-latch strobe/result.
interface err_retry_ctrl_if
    import usc_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    // 4-phase: req rises with data stable, ack rises, req falls, ack falls.
    // Left: Lreq/Ldata in, Lack out. Right: Rreq/Rdata out, Rack in.
    logic                Lreq;
    logic [WIDTH-1:0]    Ldata;
    logic                Lack;
    logic                Rreq;
    logic [WIDTH-1:0]    Rdata;
    logic                Rack;
    logic                sample;
    logic                Err;
    logic                fatal;
    logic [ERRCNT_W-1:0] err_count;

    modport master (
        output Lreq, Ldata, Rack, Err,
        input  Lack, Rreq, Rdata, sample, fatal, err_count
    );

    modport slave (
        input  Lreq, Ldata, Rack, Err,
        output Lack, Rreq, Rdata, sample, fatal, err_count
    );

endinterface

// File: rtl/ctrl_timer.sv
// Loadable 4-bit down-counter; stops at zero and flags it.
module ctrl_timer
    import usc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/err_retry_ctrl.sv
// Captures a left token, strobes an external error latch, replays on error up to a
// budget, then hands the token to the right side with independent 4-phase returns.
module err_retry_ctrl
    import usc_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SAMPLE_DLY = DEF_SAMPLE_DLY,
    parameter int MAX_RETRY  = DEF_MAX_RETRY,
    parameter int RETRY_EN   = DEF_RETRY_EN
) (
    input  logic                 clk,
    input  logic                 rst,
    err_retry_ctrl_if.slave      bus,
    output ctrl_state_t          dbg_state
);

    localparam logic [TIMER_W-1:0] RELOAD    = TIMER_W'(SAMPLE_DLY - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
    localparam bit                 CAN_RETRY = (RETRY_EN != 0);

    ctrl_state_t         state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
    logic                lack_q, lack_d;
    logic                rreq_q, rreq_d;
    logic                tmr_load, tmr_dec, tmr_zero;

    ctrl_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (RELOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            retry_q  <= '0;
            errcnt_q <= '0;
            lack_q   <= 1'b0;
            rreq_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            retry_q  <= retry_d;
            errcnt_q <= errcnt_d;
            lack_q   <= lack_d;
            rreq_q   <= rreq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        retry_d  = retry_q;
        errcnt_d = errcnt_q;
        lack_d   = lack_q;
        rreq_d   = rreq_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A still-high Rack means the right side has not returned the last token.
                if (bus.Lreq && !bus.Rack) begin
                    data_d   = bus.Ldata;
                    retry_d  = '0;
                    tmr_load = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tmr_zero) state_d = ST_CHECK;
                else          tmr_dec = 1'b1;
            end
            ST_CHECK: begin
                if (!bus.Err) begin
                    lack_d  = 1'b1;
                    rreq_d  = 1'b1;
                    state_d = ST_HS;
                end else begin
                    errcnt_d = sat_inc(errcnt_q);
                    if (CAN_RETRY && (retry_q < RETRY_LIM)) begin
                        retry_d  = retry_q + 1'b1;
                        data_d   = bus.Ldata;
                        tmr_load = 1'b1;
                        state_d  = ST_WAIT;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_HS: begin
                if (lack_q && !bus.Lreq) lack_d = 1'b0;
                if (rreq_q && bus.Rack)  rreq_d = 1'b0;
                if (!lack_q && !rreq_q && !bus.Rack) state_d = ST_IDLE;
            end
            ST_FAIL: begin
                lack_d = 1'b0;
                rreq_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.Lack      = lack_q;
    assign bus.Rreq      = rreq_q;
    assign bus.Rdata     = data_q;
    assign bus.sample    = (state_q == ST_WAIT) && tmr_zero;
    assign bus.fatal     = (state_q == ST_FAIL);
    assign bus.err_count = errcnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_err_retry_ctrl.sv
// Bench for err_retry_ctrl: directed scenarios plus randomized 4-phase traffic,
// checked each cycle against a timestamp-based behavioural model.
module tb_err_retry_ctrl;
  import usc_ctrl_pkg::*;

  localparam int W    = 8;
  localparam int DLY  = 2;
  localparam int MAXR = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  err_retry_ctrl_if #(.WIDTH(W)) bus ();
  err_retry_ctrl_if #(.WIDTH(W)) bus_nr ();
  ctrl_state_t st, st_nr;

  err_retry_ctrl #(.WIDTH(W), .SAMPLE_DLY(DLY), .MAX_RETRY(MAXR), .RETRY_EN(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(st));

  err_retry_ctrl #(.WIDTH(W), .SAMPLE_DLY(DLY), .MAX_RETRY(MAXR), .RETRY_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .bus(bus_nr), .dbg_state(st_nr));

  // input sources: directed values from main, or reactive environment
  logic         env_on = 1'b0, env_fixed = 1'b0, err_rand = 1'b0;
  logic         dir_lreq = 1'b0, dir_rack = 1'b0, dir_err = 1'b0;
  logic [W-1:0] dir_ldata = '0;
  logic         env_lreq = 1'b0, env_rack = 1'b0, env_err = 1'b0;
  logic [W-1:0] env_ldata = '0;

  assign bus.Lreq  = env_on ? env_lreq  : dir_lreq;
  assign bus.Ldata = env_on ? env_ldata : dir_ldata;
  assign bus.Rack  = env_on ? env_rack  : dir_rack;
  assign bus.Err   = env_on ? env_err   : dir_err;
  assign bus_nr.Lreq  = bus.Lreq;
  assign bus_nr.Ldata = bus.Ldata;
  assign bus_nr.Rack  = bus.Rack;
  assign bus_nr.Err   = bus.Err;

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int dly();
    return env_fixed ? 5 : int'($urandom_range(0, 6));
  endfunction

  // ---------------- behavioural model ----------------
  // Token timing is kept as timestamps: the error check happens DLY+1 edges
  // after a capture, the sample strobe is visible DLY-1 edges after it.
  int           cyc = 0;
  bit           m_busy, m_hs, m_lack, m_rreq, m_fatal;
  int           m_cap, m_tries, m_errs;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin : model
    bit olack, orreq;
    if (rst) begin
      m_busy = 0; m_hs = 0; m_lack = 0; m_rreq = 0; m_fatal = 0;
      m_tries = 0; m_errs = 0; m_data = '0;
      exp_q.delete();
    end else begin
      cyc++;
      if (m_fatal) begin
        m_lack = 0;
      end else if (m_busy) begin
        if (cyc - m_cap == DLY + 1) begin
          if (bus.Err) begin
            m_errs++;
            if (m_tries < MAXR) begin
              m_tries++;
              m_data = bus.Ldata;
              m_cap  = cyc;
            end else begin
              m_busy  = 0;
              m_fatal = 1;
            end
          end else begin
            m_busy = 0; m_hs = 1; m_lack = 1; m_rreq = 1;
            exp_q.push_back(m_data);
          end
        end
      end else if (m_hs) begin
        olack = m_lack;
        orreq = m_rreq;
        if (olack && !bus.Lreq) m_lack = 0;
        if (orreq && bus.Rack)  m_rreq = 0;
        if (!olack && !orreq && !bus.Rack) m_hs = 0;
      end else if (bus.Lreq && !bus.Rack) begin
        m_busy  = 1;
        m_cap   = cyc;
        m_tries = 0;
        m_data  = bus.Ldata;
      end
    end
  end

  // ---------------- compare + scoreboard ----------------
  int n_deliv = 0;
  logic prev_rreq = 1'b0;

  always @(negedge clk) begin : compare
    bit exp_sample;
    exp_sample = m_busy && (cyc - m_cap == DLY - 1);
    chk("lack",      bus.Lack,      m_lack);
    chk("rreq",      bus.Rreq,      m_rreq);
    chk("rdata",     bus.Rdata,     m_data);
    chk("sample",    bus.sample,    exp_sample);
    chk("fatal",     bus.fatal,     m_fatal);
    chk("err_count", bus.err_count, (m_errs > 255) ? 255 : m_errs);
    if (bus.Rreq && !prev_rreq) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("sb_data", bus.Rdata, exp_q.pop_front());
      n_deliv++;
    end
    prev_rreq = bus.Rreq;
  end

  // ---------------- monitors ----------------
  int n_smp = 0, n_smp_nr = 0, n_lack = 0, n_rreq = 0;
  always @(negedge clk) begin
    if (bus.sample)    n_smp++;
    if (bus_nr.sample) n_smp_nr++;
    if (bus.Lack)      n_lack++;
    if (bus.Rreq)      n_rreq++;
  end

  // ---------------- environment drivers ----------------
  int l_ph = 0, l_cnt = 0, r_ph = 0, r_cnt = 0;

  always @(negedge clk) begin : left_drv
    if (!env_on) begin
      l_ph = 0; l_cnt = 0; env_lreq = 0; env_err = 0;
    end else begin
      case (l_ph)
        0: if (l_cnt > 0) l_cnt--;
           else begin env_lreq = 1; env_ldata = W'($urandom); l_ph = 1; l_cnt = dly(); end
        1: if (bus.Lack) begin
             if (l_cnt > 0) l_cnt--;
             else begin env_lreq = 0; l_ph = 2; end
           end else if ($urandom_range(0, 7) == 0) env_ldata = W'($urandom);
        default: if (!bus.Lack) begin l_ph = 0; l_cnt = dly(); end
      endcase
      env_err = err_rand && ($urandom_range(0, 4) == 0);
    end
  end

  always @(negedge clk) begin : right_drv
    if (!env_on) begin
      r_ph = 0; r_cnt = 0; env_rack = 0;
    end else if (r_ph == 0) begin
      if (bus.Rreq) begin
        if (r_cnt > 0) r_cnt--;
        else begin env_rack = 1; r_ph = 1; r_cnt = dly(); end
      end
    end else if (!bus.Rreq) begin
      if (r_cnt > 0) r_cnt--;
      else begin env_rack = 0; r_ph = 0; r_cnt = dly(); end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0, s1, d0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_lack",   bus.Lack, 0);
    chk("rst_rreq",   bus.Rreq, 0);
    chk("rst_sample", bus.sample, 0);
    chk("rst_fatal",  bus.fatal, 0);
    chk("rst_rdata",  bus.Rdata, 0);
    chk("rst_errcnt", bus.err_count, 0);
    chk("rst_state",  st, ST_IDLE);
    rst = 1'b0;
    step();

    // clean token 0xA5
    dir_ldata = 8'hA5; dir_lreq = 1; dir_err = 0;
    step(); chk("clean_smp_c1", bus.sample, 0); chk("clean_st_c1", st, ST_WAIT);
    step(); chk("clean_smp_c2", bus.sample, 1);
    step(); chk("clean_smp_c3", bus.sample, 0); chk("clean_lack_c3", bus.Lack, 0);
    step(); chk("clean_lack_c4", bus.Lack, 1); chk("clean_rreq_c4", bus.Rreq, 1);
    chk("clean_rdata", bus.Rdata, 8'hA5); chk("clean_errcnt", bus.err_count, 0);

    // independent return: Rack delayed 10 cycles after Lreq falls
    dir_lreq = 0;
    step(); chk("ind_lack_fall", bus.Lack, 0); chk("ind_rreq_held", bus.Rreq, 1);
    repeat (10) step();
    chk("ind_rreq_10", bus.Rreq, 1); chk("ind_state_10", st, ST_HS);
    dir_rack = 1;
    step(); chk("ind_rreq_fall", bus.Rreq, 0); chk("ind_state_hs", st, ST_HS);
    dir_rack = 0;
    step(); chk("ind_state_idle", st, ST_IDLE);

    // Lreq while Rack still high must not capture
    dir_rack = 1; dir_lreq = 1; dir_ldata = 8'h11;
    repeat (3) step();
    chk("blk_state", st, ST_IDLE); chk("blk_sample", bus.sample, 0);

    // one retry: error on first check, data changed before recapture
    dir_err = 1; dir_rack = 0; s0 = n_smp;
    for (int i = 0; i < 20 && !bus.sample; i++) step();
    chk("retry_first_sample", bus.sample, 1);
    dir_ldata = 8'h3C;
    step(); step();
    dir_err = 0;
    for (int i = 0; i < 20 && !bus.Lack; i++) step();
    chk("retry_lack",   bus.Lack, 1);
    chk("retry_rdata",  bus.Rdata, 8'h3C);
    chk("retry_errcnt", bus.err_count, 1);
    chk("retry_fatal",  bus.fatal, 0);
    chk("retry_nsmp",   n_smp - s0, 2);
    dir_lreq = 0; dir_rack = 1;
    step(); step();
    dir_rack = 0;
    repeat (3) step();
    chk("retry_idle", st, ST_IDLE);

    // exhaustion (main) and no-retry fatal (second instance)
    rst = 1; step(); rst = 0;
    s0 = n_smp; s1 = n_smp_nr; d0 = n_lack + n_rreq;
    dir_err = 1; dir_lreq = 1; dir_ldata = 8'h5A;
    repeat (40) step();
    chk("exh_nsmp",    n_smp - s0, 4);
    chk("exh_fatal",   bus.fatal, 1);
    chk("exh_errcnt",  bus.err_count, 4);
    chk("exh_no_hs",   n_lack + n_rreq - d0, 0);
    chk("exh_state",   st, ST_FAIL);
    chk("nr_nsmp",     n_smp_nr - s1, 1);
    chk("nr_fatal",    bus_nr.fatal, 1);
    chk("nr_errcnt",   bus_nr.err_count, 1);

    // reset while in handshake
    rst = 1; dir_lreq = 0; dir_err = 0; step(); rst = 0;
    dir_lreq = 1; dir_ldata = 8'hC3;
    for (int i = 0; i < 20 && !bus.Rreq; i++) step();
    chk("hsrst_rreq_pre", bus.Rreq, 1);
    rst = 1;
    step();
    chk("hsrst_rreq",  bus.Rreq, 0);
    chk("hsrst_lack",  bus.Lack, 0);
    chk("hsrst_rdata", bus.Rdata, 0);
    chk("hsrst_state", st, ST_IDLE);
    dir_lreq = 0; rst = 0; s0 = n_smp;
    repeat (5) step();
    chk("hsrst_nostrobe", n_smp - s0, 0);

    // 20 back-to-back tokens, fixed 5-cycle environment delays
    d0 = n_deliv;
    env_fixed = 1; err_rand = 0; env_on = 1;
    for (int i = 0; i < 3000 && (n_deliv - d0) < 20; i++) step();
    chk("b2b_delivered", n_deliv - d0, 20);

    // randomized traffic with errors and occasional resets
    env_fixed = 0; err_rand = 1; d0 = n_deliv;
    for (int i = 0; i < 4000; i++) begin
      step();
      rst = (bus.fatal && $urandom_range(0, 3) == 0) || ($urandom_range(0, 399) == 0);
    end
    rst = 0;
    chk("rand_progress", (n_deliv - d0) > 40, 1);
    env_on = 0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/err_retry_ctrl.md
ERR_RETRY_CTRL -- requirements
Module: err_retry_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bundle width in bits (1..64).
REQ-002 SHALL have parameter SAMPLE_DLY, default 2, cycles from capture to error-sample pulse (1..15).
REQ-003 SHALL have parameter MAX_RETRY, default 3, replays allowed per token before fatal (0..7).
REQ-004 SHALL have parameter RETRY_EN, default 1; 0 makes any detected error fatal at once.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 Lreq  input  1  left 4-phase request; synchronous to clk.
REQ-008 Ldata  input  WIDTH  left data bundle, valid while Lreq=1.
REQ-009 Lack  output  1  left acknowledge.
REQ-010 Rreq  output  1  right 4-phase request.
REQ-011 Rdata  output  WIDTH  captured data, stable while Rreq=1.
REQ-012 Rack  input  1  right acknowledge.
REQ-013 sample  output  1  one-cycle strobe to the error-detecting latch.
REQ-014 Err  input  1  error-detector result, valid in the cycle after sample.
REQ-015 fatal  output  1  sticky: retry budget exhausted.
REQ-016 err_count  output  8  saturating total of detected errors since reset.

Function
REQ-017 SHALL implement states IDLE, WAIT, CHECK, HS, FAIL.
REQ-018 IDLE: Lreq=1 and Rack=0 -> capture Ldata into data reg, retry=0, timer=SAMPLE_DLY-1, go WAIT.
REQ-019 IDLE with Lreq=1 and Rack=1 (previous token not returned) SHALL stay in IDLE.
REQ-020 WAIT: timer decrements each cycle; at timer=0 assert sample for exactly one cycle and go CHECK.
REQ-021 CHECK, Err=0 -> go HS with Lack=1 and Rreq=1 asserted from the next cycle.
REQ-022 CHECK, Err=1, RETRY_EN=1, retry<MAX_RETRY -> retry+1, recapture Ldata, reload timer, go WAIT.
REQ-023 CHECK, Err=1, and RETRY_EN=0 or retry=MAX_RETRY -> go FAIL.
REQ-024 Each CHECK with Err=1 SHALL increment err_count, saturating at 255.
REQ-025 HS: Lack falls the cycle after Lreq=0 is seen; Rreq falls the cycle after Rack=1 is seen; left and right sides return independently.
REQ-026 HS -> IDLE when Lack=0 and Rreq=0 and Rack=0 (all in the same cycle).
REQ-027 Lack SHALL never assert before the token passes CHECK; Rdata SHALL not change while Rreq=1.
REQ-028 FAIL: fatal=1, Lack=0, Rreq=0, sample=0; only rst exits.
REQ-029 Lreq falling during WAIT or CHECK is a protocol violation; behaviour unspecified, bench excludes it.
REQ-030 sample SHALL be 0 in every state except the last WAIT cycle.

Reset
REQ-031 rst=1 at a rising edge -> state IDLE; Lack, Rreq, sample, fatal = 0; Rdata, err_count, retry, timer = 0.
REQ-032 Reset mid-operation (any state, including HS or FAIL) SHALL abandon the token with no further strobes.

Structure
REQ-033 Shared package usc_ctrl_pkg SHALL hold the state enumeration and parameter defaults/limits.
REQ-034 Sub-module ctrl_timer (loadable 4-bit down-counter with zero flag) SHALL provide the WAIT delay.
REQ-035 Implementation SHALL be a single registered FSM plus datapath registers; no combinational paths from Lreq/Rack to Lack/Rreq.

Verification
REQ-036 Clean token: WIDTH=8, Ldata=0xA5, Err=0 -> sample 2 cycles after capture, Rdata=0xA5, Rreq and Lack asserted 4 cycles after Lreq rise, err_count=0.
REQ-037 One retry: Err=1 on first CHECK, 0 on second, Ldata changed to 0x3C before recapture -> two sample strobes, Rdata=0x3C, err_count=1, fatal=0.
REQ-038 Exhaustion: MAX_RETRY=3, Err always 1 -> four sample strobes, fatal=1, err_count=4, Lack and Rreq never asserted.
REQ-039 RETRY_EN=0, Err=1 on first CHECK -> fatal=1 after one sample strobe, err_count=1.
REQ-040 Independent return: Rack delayed 10 cycles after Lreq falls -> Lack falls 1 cycle after Lreq=0, IDLE entered only after Rack=0; 20 back-to-back tokens with 5-cycle environment delays all delivered in order.
REQ-041 Reset in HS with Rreq=1 -> next cycle Rreq=0, Lack=0, Rdata=0, state IDLE.
